// File: rtl/seat_write_arbiter.sv
// seat_write_arbiter: round-robin arbiter for the seat table write port, plus the minutes-of-day clock
module seat_write_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int STU_W         = 32,
    parameter int SEAT_W        = 5,
    parameter int STATE_W       = 2,
    parameter int TIME_W        = 11,
    parameter int TICKS_PER_MIN = 60
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*STU_W-1:0]   i_req_student_no,
    input  logic [NUM_REQ*SEAT_W-1:0]  i_req_seat_no,
    input  logic [NUM_REQ*STATE_W-1:0] i_req_seat_state,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic                       i_time_load,
    input  logic [TIME_W-1:0]          i_time_load_val,
    output logic                       o_tbl_write,
    output logic [STU_W-1:0]           o_tbl_student_no,
    output logic [SEAT_W-1:0]          o_tbl_seat_no,
    output logic [STATE_W-1:0]         o_tbl_seat_state,
    output logic [TIME_W-1:0]          o_tbl_time,
    output logic [TIME_W-1:0]          o_time_now,
    output logic                       o_busy
);
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int PRE_W   = TICKS_PER_MIN > 1 ? $clog2(TICKS_PER_MIN) : 1;
    localparam int MAX_MIN = 1439;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t               r_state, w_state_nxt;
    logic [PTR_W-1:0]     r_rr_ptr, r_winner, w_winner;
    logic [PTR_W:0]       w_sum;
    logic [2*NUM_REQ-1:0] w_rot;
    logic                 w_found, w_capture, w_load_ok, w_tick;
    logic [PRE_W-1:0]     r_presc;
    logic [TIME_W-1:0]    r_time, r_tbl_time;
    logic [STU_W-1:0]     r_tbl_student;
    logic [SEAT_W-1:0]    r_tbl_seat;
    logic [STATE_W-1:0]   r_tbl_state;

    // Rotate so bit 0 is the kiosk at rr_ptr; the lowest set bit then wins.
    always_comb begin
        w_rot   = {i_req_valid, i_req_valid} >> r_rr_ptr;
        w_found = |w_rot[NUM_REQ-1:0];
        w_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (w_rot[k]) w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
        w_winner = w_sum >= (PTR_W+1)'(NUM_REQ) ? PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ)) : PTR_W'(w_sum);
    end

    always_comb begin
        w_capture   = r_state == S_IDLE && w_found;
        w_state_nxt = w_capture ? S_WRITE : S_IDLE;
        o_tbl_write = r_state == S_WRITE;
        o_busy      = r_state == S_WRITE;
        o_req_ready = r_state == S_WRITE ? NUM_REQ'(1) << r_winner : '0;
    end

    assign w_load_ok = i_time_load && 32'(i_time_load_val) <= MAX_MIN;
    assign w_tick    = r_presc == PRE_W'(TICKS_PER_MIN - 1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_winner      <= '0;
            r_presc       <= '0;
            r_time        <= '0;
            r_tbl_time    <= '0;
            r_tbl_student <= '0;
            r_tbl_seat    <= '0;
            r_tbl_state   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_ok) begin
                r_time  <= i_time_load_val;
                r_presc <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_time  <= 32'(r_time) == MAX_MIN ? '0 : r_time + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_capture) begin
                r_winner      <= w_winner;
                r_tbl_time    <= r_time;
                r_tbl_student <= i_req_student_no[w_winner*STU_W +: STU_W];
                r_tbl_seat    <= i_req_seat_no[w_winner*SEAT_W +: SEAT_W];
                r_tbl_state   <= i_req_seat_state[w_winner*STATE_W +: STATE_W];
            end
            if (r_state == S_WRITE)
                r_rr_ptr <= r_winner == PTR_W'(NUM_REQ - 1) ? '0 : r_winner + 1'b1;
        end
    end

    assign o_tbl_student_no = r_tbl_student;
    assign o_tbl_seat_no    = r_tbl_seat;
    assign o_tbl_seat_state = r_tbl_state;
    assign o_tbl_time       = r_tbl_time;
    assign o_time_now       = r_time;
endmodule
